// File: rtl/hpdcache_wrrarb.sv
// Weighted round-robin arbiter.
//
// Grants one of N requesters per cycle. The grant is decoded combinationally
// from registered state (ptr_q, credit_q) and the current request vector. A
// newly selected owner may keep the grant for up to its weight in consecutive
// transfers. A weight of 0 counts as 1. While the downstream stalls
// (ready_i=0), the grant stays on the owner and no credit is spent.
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset; outputs forced to 0 while high
//   req_i         request vector, one bit per requester
//   weight_i      per-requester weights, requester i in [i*WEIGHT_W +: WEIGHT_W]
//   ready_i       downstream accepts the granted request this cycle
//   gnt_o         one-hot-or-zero grant
//   gnt_idx_o     index of the granted requester, 0 when nothing is granted
//   burst_last_o  current grant is the last transfer of the owner's burst
module hpdcache_wrrarb #(
    parameter int unsigned N        = 4,
    parameter int unsigned WEIGHT_W = 4,
    localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N-1:0]          req_i,
    input  logic [N*WEIGHT_W-1:0] weight_i,
    input  logic                  ready_i,
    output logic [N-1:0]          gnt_o,
    output logic [IdxW-1:0]       gnt_idx_o,
    output logic                  burst_last_o
);

    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W:0]   credit_q, credit_d;

    logic                hold;
    logic                win_found;
    logic [IdxW-1:0]     win_idx;
    logic [IdxW-1:0]     cand;
    logic [WEIGHT_W-1:0] sel_w;
    logic [WEIGHT_W:0]   eff_w;
    logic [IdxW-1:0]     owner;

    // The owner keeps the grant only while it still has credit and still requests.
    // If it drops its request mid-burst, the rest of its credit is lost and a fresh
    // search runs in the same cycle.
    assign hold = (credit_q != '0) && req_i[ptr_q];

    // Round-robin search starting one past the last owner, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % N);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Weights are read only at fresh selection, so changes during a burst are ignored.
    assign sel_w = weight_i[win_idx*WEIGHT_W +: WEIGHT_W];
    assign eff_w = (sel_w == '0) ? (WEIGHT_W+1)'(1) : {1'b0, sel_w};

    assign owner = hold ? ptr_q : win_idx;

    always_comb begin
        gnt_o        = '0;
        gnt_idx_o    = '0;
        burst_last_o = 1'b0;
        if (!rst_i && (hold || win_found)) begin
            gnt_o[owner] = 1'b1;
            gnt_idx_o    = owner;
            burst_last_o = hold ? (credit_q == (WEIGHT_W+1)'(1))
                                : (eff_w == (WEIGHT_W+1)'(1));
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        credit_d = '0;
        if (hold) begin
            credit_d = ready_i ? credit_q - (WEIGHT_W+1)'(1) : credit_q;
        end else if (win_found) begin
            ptr_d    = win_idx;
            // A transfer that is accepted on the selection cycle uses one credit at once.
            credit_d = ready_i ? eff_w - (WEIGHT_W+1)'(1) : eff_w;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // Reset to N-1 so the first search starts at requester 0.
            ptr_q    <= IdxW'(N - 1);
            credit_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

endmodule

// File: doc/hpdcache_wrrarb.md
Name: hpdcache_wrrarb

Overview:
- Parametrised weighted round-robin arbiter; successor to the plain single-grant round-robin arbiter used in the cache request paths.
- Grants one of N requesters per cycle, combinationally from registered state.
- Each winner may keep the grant for up to a programmable number of consecutive transfers (its weight).
- The grant is held stable while the downstream is not ready.
- Used for refill/write-buffer/miss-handler port sharing where bandwidth must be apportioned unevenly.

Parameters:
- N, 4, number of requesters (>=2).
- WEIGHT_W, 4, width of each per-requester weight field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- req_i  in  N  request vector.
- weight_i  in  N*WEIGHT_W  weight of requester i in bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static.
- ready_i  in  1  downstream accepts the granted request this cycle.
- gnt_o  out  N  one-hot-or-zero grant; combinational.
- gnt_idx_o  out  $clog2(N)  index of granted requester; 0 when gnt_o==0.
- burst_last_o  out  1  current grant is the last of the owner's burst (credit_q==1, or a fresh selection with effective weight 1).

Behaviour:
- State:
  - ptr_q: current/last owner index. Reset value N-1, so the first search starts at index 0.
  - credit_q [WEIGHT_W:0]: transfers remaining for the owner. Reset value 0.
- While rst_i is asserted: gnt_o=0, gnt_idx_o=0, burst_last_o=0. State clears immediately; reset is asynchronous.
- Effective weight: eff_w(i) = weight_i[i], with 0 treated as 1.
- Hold condition: credit_q>0 and req_i[ptr_q]=1.
  - gnt_o = onehot(ptr_q). No new arbitration.
- Otherwise, if req_i!=0:
  - Round-robin search starts at ptr_q+1 and wraps modulo N.
  - The first set req_i bit wins, index w; gnt_o = onehot(w).
- If req_i==0: gnt_o=0.
- Work conserving: req_i!=0 implies gnt_o!=0 in the same cycle.
- Register update on each rising edge:
  - Fresh selection (not hold), req_i!=0: ptr_q<=w.
    - credit_q<=eff_w(w)-1 if ready_i=1.
    - credit_q<=eff_w(w) if ready_i=0.
  - Hold, ready_i=1: credit_q<=credit_q-1.
  - Hold, ready_i=0: no change. The grant stays stable for as many cycles as ready_i stays low.
  - credit_q>0 but req_i[ptr_q]=0 (owner dropped mid-burst): remaining credit is discarded.
    - Fresh search from ptr_q+1 in the same cycle.
    - Update as for a fresh selection, or credit_q<=0 if req_i==0.
  - No request: ptr_q unchanged, credit_q<=0.
- Weight sampling:
  - weight_i is sampled only at fresh selection.
  - Changes during a burst do not affect the current burst.
- Wrap-around: after owner N-1, the search continues at index 0.
- A single requester with continuous req is re-granted every cycle. On burst end it is re-selected with a fresh credit.
- Sustained load: each requester i receives exactly eff_w(i) consecutive transfers per round.
- Invariants to be asserted in the bench:
  - $onehot0(gnt_o).
  - Work conservation.
  - gnt_o stable while ready_i=0 and the granted req is held.
  - gnt_idx_o consistent with gnt_o.

Test Plan:
- Reset, N=4, all weights 1, req=1111, ready=1 for 5 cycles -> gnt_o 0001, 0010, 0100, 1000, 0001; burst_last_o=1 every cycle.
- w0=3, w1=1, req=0011, ready=1 -> gnt_o 01, 01, 01, 10, 01, 01, 01, 10; burst_last_o high on the 3rd and 4th grants.
- req=0110, weights 1, ready=0 for 3 cycles then 1 -> gnt_o=0010 stable for 4 cycles (transfer on the 4th), then 0100.
- w0=4, req=0101, ready=1; req0 drops after 2 grants -> gnt_o=0100 in the same cycle as the drop; credit discarded; next round starts at index 3 then wraps to 0.
- Weight 0 on all requesters, req=1001 -> behaves as weight 1: 0001, 1000, 0001 (wrap 3->0 verified).
- Assert rst_i asynchronously mid-burst (credit_q=2 on index 2), release with req=1100 -> gnt_o=0 during reset, then 0100 (search from index 0).
